// File: rtl/axi4_sub_pkg.sv
// axi4_sub_pkg: shared types for the axi4_sub_mem single-beat AXI4 subordinate.
//   resp_t    : AXI response codes returned on BRESP/RRESP
//   w_state_t : write-channel FSM states
//   r_state_t : read-channel FSM states
//   sel_resp  : maps a chip-select match onto OKAY/DECERR
package axi4_sub_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_DATA
  } r_state_t;

  function automatic resp_t sel_resp(input logic sel);
    return sel ? OKAY : DECERR;
  endfunction

endpackage

// File: rtl/axi4_sub_mem_if.sv
// axi4_sub_mem_if: AW/W/B/AR/R signal bundle between an AXI4 manager and the
// axi4_sub_mem subordinate. Single-beat only, so no LEN/SIZE/BURST/ID fields.
//   slave  modport : used by axi4_sub_mem
//   master modport : used by the manager side (testbench or interconnect)
// Build option: AXI4_SUB_WSTRB_EN adds the WSTRB byte-strobe signal.
interface axi4_sub_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);

  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
`ifdef AXI4_SUB_WSTRB_EN
  logic [DATA_W/8-1:0] WSTRB;
`endif
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
`ifdef AXI4_SUB_WSTRB_EN
    input  WSTRB,
`endif
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
`ifdef AXI4_SUB_WSTRB_EN
    output WSTRB,
`endif
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi4_sub_ram.sv
// axi4_sub_ram: simple dual-port synchronous word RAM.
//   clk_i     : clock, rising edge
//   we_i      : write enable
//   waddr_i   : write word index
//   wdata_i   : write data
//   wbe_i     : per-byte write enables
//   re_i      : read enable; rdata_o only updates when set
//   raddr_i   : read word index
//   rdata_o   : registered read data
// A read and write to the same index on one edge returns the old word.
module axi4_sub_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wbe_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Non-blocking read and write in one block gives read-first on collision.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wbe_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi4_sub_mem.sv
// axi4_sub_mem: single-beat AXI4 subordinate backed by an on-chip word RAM.
//   aCLK   : clock, rising edge
//   ARESET : synchronous active-high reset (aborts both channels)
//   bus    : axi4_sub_mem_if.slave (AW/W/B and AR/R channels)
// Address bit [ADDR_W-1] is the chip select (match SEL_VAL); the low MEM_AW
// bits index the RAM, any bits in between are ignored. Unselected accesses
// answer DECERR with no write / zero read data.
// Build option: AXI4_SUB_WSTRB_EN enables byte-strobed writes via WSTRB.
//
// Write FSM
//   state  | meaning
//   W_IDLE | accepting AW and W independently, latching whichever arrives
//   W_RESP | write done, holding BVALID/BRESP until BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for an address
//   R_MEM  | RAM read in progress for the latched address
//   R_DATA | holding RVALID/RDATA/RRESP until RREADY
module axi4_sub_mem
  import axi4_sub_pkg::*;
#(
  parameter int   DATA_W  = 32,
  parameter int   ADDR_W  = 11,
  parameter int   MEM_AW  = 10,
  parameter logic SEL_VAL = 1'b0
) (
  input  logic          aCLK,
  input  logic          ARESET,
  axi4_sub_mem_if.slave bus
);

  localparam int STRB_W = DATA_W/8;

  logic en_q;
  logic ready_ok;

  w_state_t          w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;

  r_state_t          r_state_q, r_state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rvalid_q, rvalid_d;
  resp_t             rresp_q, rresp_d;

  logic              awready, wready, arready;
  logic              aw_hs, w_hs, ar_hs;
  logic              w_commit, w_sel, r_sel;
  logic [ADDR_W-1:0] w_addr_eff;
  logic [DATA_W-1:0] w_data_eff;
  logic [STRB_W-1:0] w_strb_eff;
  logic [STRB_W-1:0] wstrb_in;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

`ifdef AXI4_SUB_WSTRB_EN
  assign wstrb_in = bus.WSTRB;
`else
  assign wstrb_in = '1;
`endif

  // READYs stay low during reset and for the first cycle after it releases.
  assign ready_ok = en_q & ~ARESET;

  assign aw_hs = bus.AWVALID & awready;
  assign w_hs  = bus.WVALID  & wready;
  assign ar_hs = bus.ARVALID & arready;

  // A channel arriving on this edge is used directly instead of its latch.
  assign w_addr_eff = aw_held_q ? awaddr_q : bus.AWADDR;
  assign w_data_eff = w_held_q  ? wdata_q  : bus.WDATA;
  assign w_strb_eff = w_held_q  ? wstrb_q  : wstrb_in;
  assign w_commit   = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign w_sel      = (w_addr_eff[ADDR_W-1] == SEL_VAL);
  assign r_sel      = (araddr_q[ADDR_W-1] == SEL_VAL);

  always_ff @(posedge aCLK) begin
    if (ARESET) begin
      en_q      <= 1'b0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      en_q      <= 1'b1;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = bus.AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = bus.WDATA;
          wstrb_d  = wstrb_in;
        end
        if (w_commit) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = sel_resp(w_sel);
        end
      end
      W_RESP: begin
        if (bus.BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d  = bus.ARADDR;
          r_state_d = R_MEM;
        end
      end
      R_MEM: begin
        r_state_d = R_DATA;
        rvalid_d  = 1'b1;
        rresp_d   = sel_resp(r_sel);
      end
      R_DATA: begin
        if (bus.RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    if (ready_ok && (w_state_q == W_IDLE)) begin
      awready = ~aw_held_q;
      wready  = ~w_held_q;
    end
    if (ready_ok && (r_state_q == R_IDLE)) begin
      arready = 1'b1;
    end
    ram_we = w_commit & w_sel & ~ARESET;
    ram_re = (r_state_q == R_MEM);
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.ARREADY = arready;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RRESP   = rresp_q;
  // The RAM output register only moves in R_MEM, so it is stable in R_DATA.
  assign bus.RDATA   = (rvalid_q && (rresp_q == OKAY)) ? ram_rdata : '0;

  axi4_sub_ram #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_ram (
    .clk_i   (aCLK),
    .we_i    (ram_we),
    .waddr_i (w_addr_eff[MEM_AW-1:0]),
    .wdata_i (w_data_eff),
    .wbe_i   (w_strb_eff),
    .re_i    (ram_re),
    .raddr_i (araddr_q[MEM_AW-1:0]),
    .rdata_o (ram_rdata)
  );

  if (ADDR_W - 1 > MEM_AW) begin : g_ignored_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr_eff[ADDR_W-2:MEM_AW], araddr_q[ADDR_W-2:MEM_AW]};
  end

endmodule

// File: tb/tb_axi4_sub_mem.sv
module tb_axi4_sub_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_sub_mem_if #(.DATA_W(32), .ADDR_W(11)) bus ();

  axi4_sub_mem #(
    .DATA_W(32), .ADDR_W(11), .MEM_AW(10), .SEL_VAL(1'b0)
  ) dut (
    .aCLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  logic [1:0] exp_b[$];
  r_exp_t     exp_r[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare on every B/R handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected: got BRESP %h handshake, expected none", bus.BRESP);
        end else begin
          chk("bresp", {30'd0, bus.BRESP}, {30'd0, exp_b.pop_front()});
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        if (exp_r.size() == 0) begin
          n_checks++;
          $display("FAIL r_unexpected: got RDATA %h handshake, expected none", bus.RDATA);
        end else begin
          r_exp_t e;
          e = exp_r.pop_front();
          chk("rresp", {30'd0, bus.RRESP}, {30'd0, e.resp});
          chk("rdata", bus.RDATA, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 50) begin
      step();
      n++;
    end
    chk("drain_in_time", {31'd0, n < 50}, 32'd1);
    step();
  endtask

  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lag, input int w_lag);
    int cyc = 0;
    bit aw_done = 0;
    bit w_done = 0;
    bus.AWADDR = addr;
    bus.WDATA  = data;
`ifdef AXI4_SUB_WSTRB_EN
    bus.WSTRB  = strb;
`else
    if (strb != 4'hF) $display("note: strobe ignored in this build");
`endif
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.AWVALID = !aw_done && (cyc >= aw_lag);
      bus.WVALID  = !w_done && (cyc >= w_lag);
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_low_pending", {31'd0, bus.WREADY}, 32'd0);
      if (aw_done && !w_done) chk("awready_low_pending", {31'd0, bus.AWREADY}, 32'd0);
      if (bus.AWVALID && bus.AWREADY) aw_done = 1;
      if (bus.WVALID && bus.WREADY) w_done = 1;
      step();
      cyc++;
    end
    bus.AWVALID = 0;
    bus.WVALID  = 0;
    chk("write_accepted", {31'd0, aw_done && w_done}, 32'd1);
  endtask

  task automatic axi_read(input logic [10:0] addr, input bit chk_lat);
    int n = 0;
    bit done = 0;
    bus.ARADDR  = addr;
    bus.ARVALID = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      done = bus.ARREADY;
      step();
      n++;
    end
    bus.ARVALID = 0;
    chk("ar_accepted", {31'd0, done}, 32'd1);
    if (chk_lat) begin
      chk("rvalid_after_1", {31'd0, bus.RVALID}, 32'd0);
      step();
      chk("rvalid_after_2", {31'd0, bus.RVALID}, 32'd1);
    end
  endtask

  function automatic r_exp_t mk_r(input logic [1:0] resp, input logic [31:0] data);
    r_exp_t e;
    e.resp = resp;
    e.data = data;
    return e;
  endfunction

  initial begin
    int n;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WVALID = 0;
    bus.BREADY = 1;  bus.ARADDR = '0;  bus.ARVALID = 0; bus.RREADY = 1;
`ifdef AXI4_SUB_WSTRB_EN
    bus.WSTRB = 4'hF;
`endif

    // Reset values
    repeat (3) step();
    chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    chk("rst_wready",  {31'd0, bus.WREADY},  32'd0);
    chk("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    chk("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
    chk("rst_bresp",   {30'd0, bus.BRESP},   32'd0);
    chk("rst_rresp",   {30'd0, bus.RRESP},   32'd0);
    chk("rst_rdata",   bus.RDATA,            32'd0);
    rst = 0;
    chk("ready_low_at_release", {31'd0, bus.AWREADY}, 32'd0);
    step();
    chk("awready_after_rst", {31'd0, bus.AWREADY}, 32'd1);
    chk("wready_after_rst",  {31'd0, bus.WREADY},  32'd1);
    chk("arready_after_rst", {31'd0, bus.ARREADY}, 32'd1);

    // Same-cycle AW+W, one-cycle BVALID pulse, then read back with latency
    exp_b.push_back(2'b00);
    axi_write(11'h005, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("bvalid_pulse_hi", {31'd0, bus.BVALID}, 32'd1);
    step();
    chk("bvalid_pulse_lo", {31'd0, bus.BVALID}, 32'd0);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'hDEADBEEF));
    axi_read(11'h005, 1);
    drain();

    // W ahead of AW, then AW ahead of W
    exp_b.push_back(2'b00);
    axi_write(11'h00A, 32'h11111111, 4'hF, 3, 0);
    drain();
    exp_b.push_back(2'b00);
    axi_write(11'h00B, 32'h22222222, 4'hF, 0, 3);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'h11111111));
    axi_read(11'h00A, 0);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'h22222222));
    axi_read(11'h00B, 0);
    drain();

    // Unselected address: DECERR, no write, zero read data
    exp_b.push_back(2'b11);
    axi_write(11'h405, 32'h55555555, 4'hF, 0, 0);
    drain();
    exp_r.push_back(mk_r(2'b11, 32'h00000000));
    axi_read(11'h405, 0);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'hDEADBEEF));
    axi_read(11'h005, 0);
    drain();

    // B back-pressure
    bus.BREADY = 0;
    exp_b.push_back(2'b11);
    axi_write(11'h40C, 32'h33333333, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid",  {31'd0, bus.BVALID},  32'd1);
      chk("bstall_bresp",   {30'd0, bus.BRESP},   32'd3);
      chk("bstall_awready", {31'd0, bus.AWREADY}, 32'd0);
      chk("bstall_wready",  {31'd0, bus.WREADY},  32'd0);
      step();
    end
    bus.BREADY = 1;
    drain();

    // R back-pressure
    bus.RREADY = 0;
    exp_r.push_back(mk_r(2'b00, 32'h11111111));
    axi_read(11'h00A, 0);
    n = 0;
    while (!bus.RVALID && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("rstall_rvalid", {31'd0, bus.RVALID}, 32'd1);
      chk("rstall_rdata",  bus.RDATA,           32'h11111111);
      chk("rstall_rresp",  {30'd0, bus.RRESP},  32'd0);
      step();
    end
    bus.RREADY = 1;
    drain();

    // Read-first collision on index 7
    exp_b.push_back(2'b00);
    axi_write(11'h007, 32'h77777777, 4'hF, 0, 0);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'h77777777));
    exp_b.push_back(2'b00);
    bus.ARADDR = 11'h007;
    bus.ARVALID = 1;
    @(negedge clk);
    chk("coll_arready", {31'd0, bus.ARREADY}, 32'd1);
    step();
    bus.ARVALID = 0;
    bus.AWADDR = 11'h007;
    bus.WDATA  = 32'hAAAA0000;
`ifdef AXI4_SUB_WSTRB_EN
    bus.WSTRB  = 4'hF;
`endif
    bus.AWVALID = 1;
    bus.WVALID  = 1;
    @(negedge clk);
    chk("coll_awready", {31'd0, bus.AWREADY}, 32'd1);
    chk("coll_wready",  {31'd0, bus.WREADY},  32'd1);
    step();
    bus.AWVALID = 0;
    bus.WVALID  = 0;
    drain();
    exp_r.push_back(mk_r(2'b00, 32'hAAAA0000));
    axi_read(11'h007, 0);
    drain();

    // Reset while W is held and AW pending
    bus.WDATA  = 32'h99999999;
    bus.WVALID = 1;
    n = 0;
    begin
      bit got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        got = bus.WREADY;
        step();
        n++;
      end
      chk("held_w_accepted", {31'd0, got}, 32'd1);
    end
    bus.WVALID = 0;
    rst = 1;
    step();
    chk("midrst_awready", {31'd0, bus.AWREADY}, 32'd0);
    chk("midrst_wready",  {31'd0, bus.WREADY},  32'd0);
    chk("midrst_arready", {31'd0, bus.ARREADY}, 32'd0);
    chk("midrst_bvalid",  {31'd0, bus.BVALID},  32'd0);
    step();
    rst = 0;
    chk("midrst_release_awready", {31'd0, bus.AWREADY}, 32'd0);
    step();
    chk("postrst_awready", {31'd0, bus.AWREADY}, 32'd1);
    chk("postrst_wready",  {31'd0, bus.WREADY},  32'd1);
    chk("postrst_bvalid",  {31'd0, bus.BVALID},  32'd0);
    exp_b.push_back(2'b00);
    axi_write(11'h00A, 32'h44444444, 4'hF, 0, 4);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'h44444444));
    axi_read(11'h00A, 0);
    drain();

`ifdef AXI4_SUB_WSTRB_EN
    exp_b.push_back(2'b00);
    axi_write(11'h003, 32'hFFFFFFFF, 4'hF, 0, 0);
    drain();
    exp_b.push_back(2'b00);
    axi_write(11'h003, 32'h12345678, 4'b0011, 0, 0);
    drain();
    exp_b.push_back(2'b00);
    axi_write(11'h003, 32'h00000000, 4'b0000, 0, 0);
    drain();
    exp_r.push_back(mk_r(2'b00, 32'hFFFF5678));
    axi_read(11'h003, 0);
    drain();
`endif

    chk("b_queue_empty", exp_b.size(), 32'd0);
    chk("r_queue_empty", exp_r.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
